// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing imem word reads into a 2-entry FIFO feeding decode
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [5:0]         opcode,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, addr_d, pc_inc;
  logic req_d;
  logic [INSTR_W-1:0] buf_i [2];
  logic [ADDR_W-1:0] buf_p [2];
  logic hd;
  logic [1:0] count;
  logic pop, push, space;
  assign instr_valid = count != 2'd0;
  assign instr = buf_i[hd];
  assign instr_pc = buf_p[hd];
  assign opcode = instr[INSTR_W-1 -: 6];
  assign halted = state == HALT;
  assign pop = instr_valid & instr_ready;
  assign push = (state == WAIT) & imem_ack & !redirect;
  assign space = (count == 2'd0) | ((count == 2'd1) & pop);
  assign pc_inc = pc + ADDR_W'(1);
  // next-state, next pc and next request; a redirect always reloads the pc
  always_comb begin
    state_d = state;
    pc_d = redirect ? redirect_pc : pc;
    req_d = imem_req;
    addr_d = imem_addr;
    case (state)
      IDLE: begin
        if (halt) state_d = HALT;
        else if (!redirect && count != 2'd2) begin
          req_d = 1'b1;
          addr_d = pc;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack && redirect) begin
          req_d = 1'b0;
          state_d = IDLE;
        end else if (imem_ack) begin
          pc_d = pc_inc;
          req_d = space & !halt;
          addr_d = (space & !halt) ? pc_inc : imem_addr;
          state_d = (space & !halt) ? WAIT : halt ? HALT : IDLE;
        end else if (redirect) state_d = DROP;
      end
      DROP: begin
        if (imem_ack) begin
          req_d = 1'b0;
          state_d = halt ? HALT : IDLE;
        end
      end
      default: state_d = halt ? HALT : IDLE;
    endcase
  end
  // state, pc and the registered memory request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state <= state_d;
      pc <= pc_d;
      imem_req <= req_d;
      imem_addr <= addr_d;
    end
  // instruction FIFO; a redirect flushes it even when a pop coincides
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_i[0] <= '0;
      buf_i[1] <= '0;
      buf_p[0] <= '0;
      buf_p[1] <= '0;
      hd <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        buf_i[hd ^ count[0]] <= imem_rdata;
        buf_p[hd ^ count[0]] <= imem_addr;
      end
      if (pop) hd <= ~hd;
      count <= redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-configurable memory
module tb_fetch_unit;
  logic clk, rst_n;
  logic req, ack, ready, redirect, halt, halted, valid;
  logic [15:0] addr, redirect_pc, ipc;
  logic [31:0] rdata, instr;
  logic [5:0] opc;
  logic req1, valid1, halted1;
  logic [15:0] addr1, ipc1;
  logic [31:0] instr1;
  logic [5:0] opc1;
  int lat, wcnt;
  int checks = 0, errors = 0;

  function automatic logic [5:0] op(input logic [15:0] a);
    return a[5:0] ^ 6'h2A;
  endfunction
  function automatic logic [31:0] mw(input logic [15:0] a);
    return {op(a), 10'h155, a};
  endfunction

  assign ack = req && (wcnt >= lat);
  assign rdata = mw(addr);
  always @(posedge clk) wcnt <= (req && !ack) ? wcnt + 1 : 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .instr_valid(valid), .instr_ready(ready), .instr(instr),
    .instr_pc(ipc), .opcode(opc), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
    .clk(clk), .rst_n(rst_n), .imem_req(req1), .imem_addr(addr1), .imem_ack(req1),
    .imem_rdata(mw(addr1)), .instr_valid(valid1), .instr_ready(1'b1), .instr(instr1),
    .instr_pc(ipc1), .opcode(opc1), .redirect(1'b0), .redirect_pc(16'h0000),
    .halt(1'b0), .halted(halted1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_ipc"}, ipc, 0);
    chk({tag, "_opc"}, opc, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    rst_n = 0; ready = 1; redirect = 0; redirect_pc = 0; halt = 0; lat = 0;
    @(negedge clk);
    chk_reset("rst");
    chk("rst_addr1", addr1, 16'hFFFE);
    chk("rst_req1", req1, 0);
    rst_n = 1;
    @(negedge clk);
    chk("zw_req", req, 1);
    chk("zw_addr0", addr, 0);
    chk("zw_valid0", valid, 0);
    chk("wrap_a0", addr1, 16'hFFFE);
    @(negedge clk);
    chk("zw_addr1", addr, 1);
    chk("zw_valid1", valid, 1);
    chk("zw_ipc0", ipc, 0);
    chk("zw_instr0", instr, mw(16'h0000));
    chk("zw_opc0", opc, 6'h2A);
    chk("wrap_a1", addr1, 16'hFFFF);
    @(negedge clk);
    chk("zw_addr2", addr, 2);
    chk("zw_ipc1", ipc, 1);
    chk("wrap_a2", addr1, 16'h0000);
    @(negedge clk);
    chk("zw_addr3", addr, 3);
    chk("zw_ipc2", ipc, 2);
    chk("zw_opc2", opc, op(16'h0002));
    rst_n = 0; ready = 0;
    #1;
    chk_reset("async");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("nr_req", req, 1);
    chk("nr_addr0", addr, 0);
    @(negedge clk);
    chk("nr_addr1", addr, 1);
    chk("nr_ipc0", ipc, 0);
    @(negedge clk);
    chk("nr_reqdrop", req, 0);
    @(negedge clk);
    chk("nr_reqlow", req, 0);
    chk("nr_full_ipc", ipc, 0);
    chk("nr_valid", valid, 1);
    ready = 1;
    @(negedge clk);
    chk("nr_ipc1", ipc, 1);
    chk("nr_noissue", req, 0);
    @(negedge clk);
    chk("nr_empty", valid, 0);
    chk("nr_addr2", addr, 2);
    chk("nr_req2", req, 1);
    @(negedge clk);
    chk("nr_ipc2", ipc, 2);
    rst_n = 0; lat = 3;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rd_addr0", addr, 0);
    @(negedge clk);
    redirect = 1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 0;
    chk("rd_hold_req", req, 1);
    chk("rd_hold_addr", addr, 0);
    chk("rd_empty0", valid, 0);
    @(negedge clk);
    chk("rd_hold_addr2", addr, 0);
    @(negedge clk);
    chk("rd_req_low", req, 0);
    chk("rd_discard", valid, 0);
    @(negedge clk);
    chk("rd_newreq", req, 1);
    chk("rd_newaddr", addr, 16'h0040);
    chk("rd_empty1", valid, 0);
    repeat (4) @(negedge clk);
    chk("rd_valid", valid, 1);
    chk("rd_ipc", ipc, 16'h0040);
    chk("rd_opc", opc, op(16'h0040));
    rst_n = 0; lat = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ra_addr0", addr, 0);
    @(negedge clk);
    chk("ra_valid", valid, 1);
    redirect = 1; redirect_pc = 16'h0100;
    @(negedge clk);
    redirect = 0;
    chk("ra_flush", valid, 0);
    chk("ra_req", req, 0);
    @(negedge clk);
    chk("ra_newaddr", addr, 16'h0100);
    chk("ra_newreq", req, 1);
    @(negedge clk);
    chk("ra_ipc", ipc, 16'h0100);
    rst_n = 0; lat = 2; ready = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("h_addr0", addr, 0);
    halt = 1;
    @(negedge clk);
    chk("h_req_held", req, 1);
    chk("h_not_halted", halted, 0);
    @(negedge clk);
    chk("h_wait_valid", valid, 0);
    @(negedge clk);
    chk("h_halted", halted, 1);
    chk("h_req_low", req, 0);
    chk("h_pushed", valid, 1);
    chk("h_ipc0", ipc, 0);
    ready = 1;
    @(negedge clk);
    chk("h_drained", valid, 0);
    chk("h_still_halted", halted, 1);
    halt = 0;
    @(negedge clk);
    chk("h_unhalted", halted, 0);
    chk("h_idle_req", req, 0);
    @(negedge clk);
    chk("h_resume_req", req, 1);
    chk("h_resume_addr", addr, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry FIFO. It presents the head instruction and its 6-bit opcode field to decode/control with a valid/ready handshake. Execute can redirect the PC on a jump or branch, and fetch can be halted.

## Interface
- ADDR_W, 16, instruction-memory word-address width
- INSTR_W, 32, instruction width; opcode is the top 6 bits
- RESET_PC, 0, PC value after reset
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request, registered
- imem_addr  out  ADDR_W  read word address, registered
- imem_ack  in  1  read data valid, sampled only while imem_req=1
- imem_rdata  in  INSTR_W  read data, valid when imem_ack=1
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts the head
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  address of the head instruction
- opcode  out  6  instr[INSTR_W-1:INSTR_W-6]
- redirect  in  1  flush the pipeline and load the PC from redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- halt  in  1  level; stop issuing new requests
- halted  out  1  high while in the HALT state

## Operation
- Registers: pc, FSM state, 2-entry FIFO of {instr, pc} pairs, and count (0..2).
- The FIFO head drives instr, instr_pc and opcode. instr_valid = (count != 0).
- Pop: occurs on a cycle where instr_valid & instr_ready.
- Push: occurs on ack in WAIT when redirect=0. It stores {imem_rdata, imem_addr}.
- A push never occurs while the FIFO is full. The verifier asserts this.
- Space check: space = (count - pop + push) < 2, evaluated for the next cycle.
- IDLE (imem_req=0)
  - If halt, go to HALT.
  - Else if count < 2, set imem_req=1 and imem_addr=pc, and go to WAIT.
  - Redirect sets pc=redirect_pc and flushes the FIFO.
  - Redirect has priority over issuing a request in the same cycle; the next issue uses the new pc.
- WAIT (imem_req=1, imem_addr held stable)
  - Ack with no redirect: push the word and set pc=pc+1.
    - If space & !halt, keep imem_req=1, set imem_addr=pc+1, and stay in WAIT.
    - Else drop imem_req and go to IDLE if !halt, or HALT if halt.
  - Ack with redirect: discard the data, set pc=redirect_pc, flush, drop imem_req, and go to IDLE.
  - Redirect with no ack: set pc=redirect_pc, flush, and go to DROP. imem_req stays high at the old address.
- DROP (imem_req=1, old address)
  - Hold the request until ack, then discard the data and go to IDLE (or HALT if halt).
  - A further redirect overwrites pc; the last one wins.
  - The FIFO stays empty.
- HALT (imem_req=0, halted=1)
  - The FIFO continues to drain.
  - Redirect updates pc and flushes.
  - When halt goes low, go to IDLE.
- Flush clears count to 0 in the same edge, regardless of a simultaneous pop.
- PC arithmetic is modulo 2^ADDR_W: pc+1 from all-ones wraps to 0.
- halt does not abort an outstanding request. That word is still pushed unless it is discarded by a redirect.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, pc=RESET_PC, count=0.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, opcode=0, halted=0.
- First imem_req rises on the first clock edge after rst_n deasserts.
- Ack may arrive in the same cycle the request is first visible; this is zero-wait memory.
- Fetch latency: instr_valid rises on the edge that samples the ack.
- Throughput: with zero-wait memory and instr_ready=1, one instruction per cycle with back-to-back addresses.
- An outstanding request is never withdrawn or re-addressed before its ack.
- Redirect-to-request:
  - From IDLE/HALT, or on the ack cycle: 1 cycle.
  - From WAIT without ack: the remaining old-request latency, then 1 cycle.
- Halt takes effect at the next issue decision. halted rises the edge after the last outstanding ack, or the edge after halt is sampled in IDLE.

## Test plan
- Zero-wait memory, instr_ready=1 after reset:
  - imem_addr runs 0,1,2,3 on consecutive cycles.
  - instr_pc follows one cycle behind the address.
  - opcode equals imem_rdata[31:26].
- instr_ready=0 from reset:
  - Exactly 2 words (pc 0,1) are buffered, then imem_req falls.
  - Raise ready: outputs pc 0,1,2,… with no loss or duplication.
- 3-cycle memory latency, redirect to 0x0040 one cycle into WAIT:
  - imem_req is held at the old address until ack; that data is not pushed.
  - The next request uses 0x0040, and the FIFO is empty meanwhile.
- Redirect to 0x0100 coincident with ack, and also with a pop:
  - Data is discarded and count becomes 0.
  - The next imem_addr is 0x0100.
- halt raised while WAIT with 2-cycle latency:
  - The outstanding word is pushed and halted=1.
  - The buffered words still drain.
  - halt=0 resumes fetch at the next sequential pc.
- RESET_PC=0xFFFE, zero-wait memory: addresses run 0xFFFE, 0xFFFF, 0x0000.
- rst_n pulsed low mid-WAIT: all outputs return to their reset values without waiting for a clock edge.
